cp0_exc_handler: RTL and testbench

- Coprocessor-0 exception responder sitting at the M stage; consumer end of the exception signalling raised by the stage exception checkers (ExcGet/ExcCode).
- Holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against synchronous exceptions, and asserts IntReq to flush the pipeline and redirect the PC to the handler.
- Services mfc0/mtc0 and eret for the datapath.

---
 rtl/cp0_exc_handler_if.sv | 29 ++
 rtl/cp0_exc_handler.sv | 132 +++++++++++++
 tb/tb_cp0_exc_handler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cp0_exc_handler_if.sv
// Datapath <-> CP0 bundle for the M-stage exception responder.
// The datapath (master) drives the M-stage state; CP0 (slave) answers with read data, EPC and IntReq.
interface cp0_exc_handler_if #(
    parameter int HWINT_W = 6
);
    logic [31:0]        PC;
    logic               BD;
    logic               ExcGet;
    logic [4:0]         ExcCode;
    logic [HWINT_W-1:0] HWInt;
    logic               WE;
    logic [4:0]         Addr;
    logic [31:0]        WData;
    logic               EretM;
    logic [31:0]        BadAddr;
    logic [31:0]        RData;
    logic [31:0]        EPCOut;
    logic               IntReq;

    modport master (
        output PC, BD, ExcGet, ExcCode, HWInt, WE, Addr, WData, EretM, BadAddr,
        input  RData, EPCOut, IntReq
    );

    modport slave (
        input  PC, BD, ExcGet, ExcCode, HWInt, WE, Addr, WData, EretM, BadAddr,
        output RData, EPCOut, IntReq
    );
endinterface

// File: rtl/cp0_exc_handler.sv
// CP0 exception responder: SR/Cause/EPC/PRId, interrupt vs. exception arbitration, mfc0/mtc0/eret.
// Optional BadVAddr register (number 8) is enabled by defining CP0_BADVADDR_EN.
module cp0_exc_handler #(
    parameter logic [31:0] PRID    = 32'h2018_1217,
    parameter int          HWINT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    cp0_exc_handler_if.slave    bus
);
    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [HWINT_W-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               cause_bd_q, cause_bd_d;
    logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
    logic [4:0]         cause_exc_q, cause_exc_d;
    logic [31:0]        epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] epc_sel;

    assign int_pend = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend = bus.ExcGet & ~exl_q;
    assign int_req  = int_pend | exc_pend;
    assign epc_sel  = bus.BD ? (bus.PC - 32'd4) : bus.PC;

    always_comb begin
        im_d        = im_q;
        exl_d       = exl_q;
        ie_d        = ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = bus.HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (int_req) begin
            // The M-stage instruction is being flushed, so its mtc0/eret is dropped.
            exl_d       = 1'b1;
            cause_exc_d = int_pend ? 5'd0 : bus.ExcCode;
            cause_bd_d  = bus.BD;
            epc_d       = epc_sel & 32'hFFFF_FFFC;
        end else begin
            if (bus.WE) begin
                if (bus.Addr == A_SR) begin
                    im_d  = bus.WData[15:10];
                    exl_d = bus.WData[1];
                    ie_d  = bus.WData[0];
                end else if (bus.Addr == A_EPC) begin
                    epc_d = bus.WData & 32'hFFFF_FFFC;
                end
            end
            // eret is applied after the SR write so a simultaneous write cannot leave EXL set.
            if (bus.EretM) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q        <= '0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            im_q        <= im_d;
            exl_q       <= exl_d;
            ie_q        <= ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        badvaddr_d = badvaddr_q;
        if (exc_pend && !int_pend && (bus.ExcCode == 5'd4 || bus.ExcCode == 5'd5)) begin
            badvaddr_d = bus.BadAddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= 32'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
        end
    end
`else
    logic unused_bad_addr;
    assign unused_bad_addr = ^bus.BadAddr;
`endif

    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] rdata;

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};

    always_comb begin
        rdata = 32'd0;
        case (bus.Addr)
            A_SR:    rdata = sr_word;
            A_CAUSE: rdata = cause_word;
            A_EPC:   rdata = epc_q;
            A_PRID:  rdata = PRID;
`ifdef CP0_BADVADDR_EN
            5'd8:    rdata = badvaddr_q;
`endif
            default: rdata = 32'd0;
        endcase
    end

    assign bus.RData  = rdata;
    assign bus.IntReq = int_req;
    // Bypass so an mtc0 EPC immediately followed by eret returns to the new address.
    assign bus.EPCOut = (bus.WE && bus.Addr == A_EPC) ? (bus.WData & 32'hFFFF_FFFC) : epc_q;
endmodule

// File: tb/tb_cp0_exc_handler.sv
// Table-driven bench for cp0_exc_handler: per-cycle vectors with hand-computed RData/IntReq/EPCOut.
module tb_cp0_exc_handler;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef CP0_BADVADDR_EN
    localparam bit BV_ON = 1'b1;
`else
    localparam bit BV_ON = 1'b0;
`endif

    cp0_exc_handler_if #(.HWINT_W(6)) bus ();

    cp0_exc_handler #(.PRID(32'h2018_1217), .HWINT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
        logic        exc_get;
        logic [4:0]  exc_code;
        logic [5:0]  hwint;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bad_addr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                input logic eret, input logic exc_get, input logic [4:0] exc_code,
                                input logic [5:0] hwint, input logic [31:0] pc, input logic bd,
                                input logic [31:0] bad_addr, input logic [31:0] exp_rdata,
                                input logic exp_irq, input logic [31:0] exp_epc);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.eret = eret;
        v.exc_get = exc_get; v.exc_code = exc_code; v.hwint = hwint;
        v.pc = pc; v.bd = bd; v.bad_addr = bad_addr;
        v.exp_rdata = exp_rdata; v.exp_irq = exp_irq; v.exp_epc = exp_epc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.WE = v.we; bus.Addr = v.addr; bus.WData = v.wdata; bus.EretM = v.eret;
        bus.ExcGet = v.exc_get; bus.ExcCode = v.exc_code; bus.HWInt = v.hwint;
        bus.PC = v.pc; bus.BD = v.bd; bus.BadAddr = v.bad_addr;
    endtask

    task automatic check32(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, got, want);
        end
    endtask

    // Drive one cycle's inputs after the edge, check combinational outputs mid-cycle, then take the edge.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #2;
        check32("rdata", idx, bus.RData, v.exp_rdata);
        check32("int_req", idx, {31'd0, bus.IntReq}, {31'd0, v.exp_irq});
        check32("epc_out", idx, bus.EPCOut, v.exp_epc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 0, 0, 0);

        //            we addr   wdata          eret exc code   hwint      pc             bd badaddr         rdata          irq epcout
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 5'd15, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h2018_1217, 0, 32'h0));
        vecs.push_back(mk(0, 5'd8,  32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h0,         0, 32'h0));
        vecs.push_back(mk(1, 5'd12, 32'h0000_FC01,  0, 0, 5'd0,  6'b000000, 32'h0000_1000, 0, 32'h0,         32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000100, 32'h0000_4000, 0, 32'h0,         32'h0000_FC01, 1, 32'h0));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000100, 32'h0000_4000, 0, 32'h0,         32'h0000_FC03, 0, 32'h0000_4000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000100, 32'h0000_4000, 0, 32'h0,         32'h0000_1000, 0, 32'h0000_4000));
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 0, 5'd0,  6'b000100, 32'h0000_4000, 0, 32'h0,         32'h0000_4000, 0, 32'h0000_4000));
        // EXL=1 masks both an exception and every interrupt line.
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 1, 5'd10, 6'b111111, 32'h0000_5000, 0, 32'h0,         32'h0000_4000, 0, 32'h0000_4000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          1, 0, 5'd0,  6'b000000, 32'h0000_5000, 0, 32'h0,         32'h0000_FC00, 0, 32'h0000_4000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000001, 32'h0000_6000, 0, 32'h0,         32'h0000_FC01, 1, 32'h0000_4000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          1, 0, 5'd0,  6'b000000, 32'h0000_6000, 0, 32'h0,         32'h0000_0400, 0, 32'h0000_6000));
        // AdES in a delay slot.
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 1, 5'd5,  6'b000000, 32'h0000_3010, 1, 32'h0000_7F08, 32'h0000_FC01, 1, 32'h0000_6000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h8000_0014, 0, 32'h0000_300C));
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h0000_300C, 0, 32'h0000_300C));
        vecs.push_back(mk(0, 5'd8,  32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         BV_ON ? 32'h0000_7F08 : 32'h0, 0, 32'h0000_300C));
        vecs.push_back(mk(0, 5'd9,  32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h0,         0, 32'h0000_300C));
        vecs.push_back(mk(1, 5'd13, 32'hFFFF_FFFF,  0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h8000_0014, 0, 32'h0000_300C));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h8000_0014, 0, 32'h0000_300C));
        // mtc0 EPC together with eret: bypass on EPCOut, no write-through on RData.
        vecs.push_back(mk(1, 5'd14, 32'h0000_3003,  1, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h0000_300C, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h0000_3000, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_3010, 0, 32'h0,         32'h0000_FC01, 0, 32'h0000_3000));
        // Interrupt and exception together, plus an mtc0 EPC that must be dropped.
        vecs.push_back(mk(1, 5'd14, 32'h0000_9000,  0, 1, 5'd10, 6'b000010, 32'h0000_7000, 0, 32'h0,         32'h0000_3000, 1, 32'h0000_9000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_0800, 0, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd14, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_7000, 0, 32'h0000_7000));
        // SR write setting EXL in the same cycle as eret leaves EXL clear.
        vecs.push_back(mk(1, 5'd12, 32'h0000_FC03,  1, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_FC03, 0, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_FC01, 0, 32'h0000_7000));
        vecs.push_back(mk(1, 5'd12, 32'hFFFF_FFFE,  0, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_FC01, 0, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_FC02, 0, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          1, 0, 5'd0,  6'b000000, 32'h0000_7000, 0, 32'h0,         32'h0000_FC02, 0, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 0, 5'd0,  6'b111111, 32'h0000_7000, 0, 32'h0,         32'h0000_FC00, 0, 32'h0000_7000));
        // AdEL with IE=0: exception taken, misaligned PC masked into EPC.
        vecs.push_back(mk(0, 5'd12, 32'h0,          0, 1, 5'd4,  6'b111111, 32'h0000_8002, 0, 32'h0000_1234, 32'h0000_FC00, 1, 32'h0000_7000));
        vecs.push_back(mk(0, 5'd13, 32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_8002, 0, 32'h0,         32'h0000_FC10, 0, 32'h0000_8000));
        vecs.push_back(mk(0, 5'd8,  32'h0,          0, 0, 5'd0,  6'b000000, 32'h0000_8002, 0, 32'h0,         BV_ON ? 32'h0000_1234 : 32'h0, 0, 32'h0000_8000));

        // Reset overrides a concurrent mtc0 EPC.
        drive(mk(1, 5'd14, 32'h0000_5554, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 0, 0, 0));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Mid-handler reset: EXL=1 and EPC=0x8000 here; nothing may survive.
        drive(mk(0, 5'd12, 32'h0, 0, 1, 5'd4, 6'b111111, 32'h0000_9000, 0, 32'h0000_ABCD, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(0, 5'd12, 32'h0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0), 100);
        apply(mk(0, 5'd13, 32'h0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0), 101);
        apply(mk(0, 5'd14, 32'h0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0), 102);
        apply(mk(0, 5'd8,  32'h0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0), 103);
        // After reset an exception is taken again immediately (EXL really cleared).
        apply(mk(0, 5'd12, 32'h0, 0, 1, 5'd10, 6'd0, 32'h0000_A000, 0, 32'h0, 32'h0, 1, 32'h0), 104);
        apply(mk(0, 5'd13, 32'h0, 0, 0, 5'd0, 6'd0, 32'h0, 0, 32'h0, 32'h0000_0028, 0, 32'h0000_A000), 105);
        drive(idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
